// File: rtl/lfsr_ctrl.sv
// lfsr_ctrl: sequencing controller for the 8-bit display-lab LFSR.
// Turns button edges into step/load strobes; recovers from the zero state.
module lfsr_ctrl #(
   parameter int TICK_DIV = 1000,
   parameter int CNT_W    = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cmd_load,
   input  logic             cmd_step,
   input  logic             cmd_run,
   input  logic             cmd_burst,
   input  logic [7:0]       burst_len,
   input  logic [7:0]       seed,
   input  logic [7:0]       lfsr_q,
   output logic             lfsr_en,
   output logic             lfsr_load,
   output logic [7:0]       lfsr_d,
   output logic [1:0]       state,
   output logic             busy,
   output logic [CNT_W-1:0] step_cnt,
   output logic             lockup
);

   localparam int TW = $clog2(TICK_DIV);
   localparam logic [TW-1:0] TMAX = TW'(TICK_DIV - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      BURST = 2'd2,
      LOAD  = 2'd3
   } state_t;

   state_t           st_q, st_d;
   logic             en_d, ld_d, lock_d;
   logic [7:0]       d_d;
   logic [CNT_W-1:0] cnt_d;
   logic [TW-1:0]    tick_q, tick_d;
   logic [7:0]       rem_q, rem_d;
   logic             p_load, p_step, p_run, p_burst;
   logic             e_load, e_step, e_run, e_burst;

   assign e_load  = cmd_load  & ~p_load;
   assign e_step  = cmd_step  & ~p_step;
   assign e_run   = cmd_run   & ~p_run;
   assign e_burst = cmd_burst & ~p_burst;

   assign state = st_q;
   assign busy  = (st_q != IDLE);

   // Register FSM state, outputs and the command history.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         st_q      <= IDLE;
         lfsr_en   <= 1'b0;
         lfsr_load <= 1'b0;
         lfsr_d    <= 8'h00;
         step_cnt  <= '0;
         lockup    <= 1'b0;
         tick_q    <= '0;
         rem_q     <= 8'h00;
         p_load    <= 1'b0;
         p_step    <= 1'b0;
         p_run     <= 1'b0;
         p_burst   <= 1'b0;
      end else begin
         st_q      <= st_d;
         lfsr_en   <= en_d;
         lfsr_load <= ld_d;
         lfsr_d    <= d_d;
         step_cnt  <= cnt_d;
         lockup    <= lock_d;
         tick_q    <= tick_d;
         rem_q     <= rem_d;
         p_load    <= cmd_load;
         p_step    <= cmd_step;
         p_run     <= cmd_run;
         p_burst   <= cmd_burst;
      end
   end

   // Pick one action per cycle: recovery, load, then per-state commands.
   always_comb begin
      st_d   = st_q;
      en_d   = 1'b0;
      ld_d   = 1'b0;
      d_d    = lfsr_d;
      cnt_d  = step_cnt;
      lock_d = lockup;
      tick_d = tick_q;
      rem_d  = rem_q;
      if (lfsr_q == 8'h00 && !lfsr_load) begin
         ld_d   = 1'b1;
         d_d    = 8'h01;
         lock_d = 1'b1;
         st_d   = IDLE;
      end else if (e_load) begin
         ld_d   = 1'b1;
         d_d    = (seed == 8'h00) ? 8'h01 : seed;
         cnt_d  = '0;
         lock_d = 1'b0;
         st_d   = LOAD;
      end else begin
         unique case (st_q)
            IDLE: begin
               if (e_burst) begin
                  if (burst_len != 8'h00) begin
                     st_d  = BURST;
                     rem_d = burst_len;
                  end
               end else if (e_run) begin
                  st_d   = RUN;
                  tick_d = '0;
               end else if (e_step) begin
                  en_d = 1'b1;
               end
            end
            RUN: begin
               if (e_run) begin
                  st_d = IDLE;
               end else if (tick_q == TMAX) begin
                  tick_d = '0;
                  en_d   = 1'b1;
               end else begin
                  tick_d = tick_q + TW'(1);
               end
            end
            BURST: begin
               en_d  = 1'b1;
               rem_d = rem_q - 8'd1;
               if (rem_q <= 8'd1) st_d = IDLE;
            end
            LOAD: st_d = IDLE;
            default: st_d = IDLE;
         endcase
         if (en_d) cnt_d = step_cnt + CNT_W'(1);
      end
   end

endmodule
